// File: rtl/cell4_stim_chk_if.sv
// Pin bundle between the cell-characterisation harness and the stimulus/checker block.
// "master" is the harness side (run control, truth table, CUT output); "slave" is the checker.
interface cell4_stim_chk_if #(
    parameter int unsigned ERRW = 5
);
    logic            start;
    logic            abort;
    logic [15:0]     tt;
    logic            nq_in;
    logic            i0;
    logic            i1;
    logic            i2;
    logic            i3;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_cnt;
    logic            fail_vld;
    logic [3:0]      fail_vec;

    modport master (
        output start, abort, tt, nq_in,
        input  i0, i1, i2, i3, busy, done, pass, err_cnt, fail_vld, fail_vec
    );

    modport slave (
        input  start, abort, tt, nq_in,
        output i0, i1, i2, i3, busy, done, pass, err_cnt, fail_vld, fail_vec
    );
endinterface

// File: rtl/cell4_stim_chk.sv
// Exhaustive 16-vector stimulus generator and truth-table checker for a 4-input combinational cell.
//
// state | meaning
// IDLE  | no run active; outputs parked at zero (results kept after an abort)
// RUN   | walking vectors 0..15, settling then sampling the CUT output
// DONE  | run finished; results held until the next start or reset
module cell4_stim_chk #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERRW   = 5
) (
    input logic              ck,
    input logic              nrst,
    cell4_stim_chk_if.slave  cut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_W = 8'(SETTLE);

    state_t          state_q;
    logic [3:0]      vec_q;
    logic [7:0]      wcnt_q;
    logic [15:0]     tt_q;
    logic [3:0]      drv_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [ERRW-1:0] err_q;
    logic            fvld_q;
    logic [3:0]      fvec_q;

    logic            mism;
    logic [ERRW-1:0] err_d;

    // The CUT is driven from registers, so its output is stable by the sample edge.
    assign mism  = cut.nq_in ^ tt_q[vec_q];
    assign err_d = (&err_q) ? err_q : err_q + 1'b1;

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            vec_q   <= 4'h0;
            wcnt_q  <= 8'h00;
            tt_q    <= 16'h0000;
            drv_q   <= 4'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= 4'h0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (cut.start) begin
                        state_q <= RUN;
                        tt_q    <= cut.tt;
                        vec_q   <= 4'h0;
                        wcnt_q  <= SETTLE_W;
                        drv_q   <= 4'h0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fvld_q  <= 1'b0;
                        fvec_q  <= 4'h0;
                    end
                end
                RUN: begin
                    if (cut.abort) begin
                        state_q <= IDLE;
                        drv_q   <= 4'h0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (wcnt_q != 8'h00) begin
                        wcnt_q <= wcnt_q - 8'h01;
                    end else begin
                        if (mism) begin
                            err_q <= err_d;
                            if (!fvld_q) begin
                                fvld_q <= 1'b1;
                                fvec_q <= vec_q;
                            end
                        end
                        if (vec_q == 4'hF) begin
                            state_q <= DONE;
                            drv_q   <= 4'h0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            // fvld_q has not yet absorbed this final sample, so fold it in here.
                            pass_q  <= !(fvld_q || mism);
                        end else begin
                            vec_q  <= vec_q + 4'h1;
                            drv_q  <= vec_q + 4'h1;
                            wcnt_q <= SETTLE_W;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    drv_q   <= 4'h0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cut.i0       = drv_q[0];
    assign cut.i1       = drv_q[1];
    assign cut.i2       = drv_q[2];
    assign cut.i3       = drv_q[3];
    assign cut.busy     = busy_q;
    assign cut.done     = done_q;
    assign cut.pass     = pass_q;
    assign cut.err_cnt  = err_q;
    assign cut.fail_vld = fvld_q;
    assign cut.fail_vec = fvec_q;

endmodule

// File: tb/tb_cell4_stim_chk.sv
// Bench for cell4_stim_chk: three configurations, behavioural CUT models, scoreboard of run results.
module tb_cell4_stim_chk;

    logic ck;
    logic nrst;

    cell4_stim_chk_if #(.ERRW(5)) if_a ();
    cell4_stim_chk_if #(.ERRW(3)) if_b ();
    cell4_stim_chk_if #(.ERRW(5)) if_c ();

    cell4_stim_chk #(.SETTLE(2), .ERRW(5)) u_a (.ck(ck), .nrst(nrst), .cut(if_a));
    cell4_stim_chk #(.SETTLE(2), .ERRW(3)) u_b (.ck(ck), .nrst(nrst), .cut(if_b));
    cell4_stim_chk #(.SETTLE(1), .ERRW(5)) u_c (.ck(ck), .nrst(nrst), .cut(if_c));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge ck) cyc++;

    // CUT models: 0 ideal NAND4, 1 stuck-at-1, 2 stuck-at-0, 3 NAND4 lagging two cycles
    logic [1:0] mode [3];
    logic [2:0] nd, d1, d2;

    assign nd[0] = ~&{if_a.i3, if_a.i2, if_a.i1, if_a.i0};
    assign nd[1] = ~&{if_b.i3, if_b.i2, if_b.i1, if_b.i0};
    assign nd[2] = ~&{if_c.i3, if_c.i2, if_c.i1, if_c.i0};

    always @(posedge ck) begin
        d1 <= nd;
        d2 <= d1;
    end

    function automatic logic nq_model(input logic [1:0] m, input logic n, input logic d);
        case (m)
            2'd0:    return n;
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return d;
        endcase
    endfunction

    assign if_a.nq_in = nq_model(mode[0], nd[0], d2[0]);
    assign if_b.nq_in = nq_model(mode[1], nd[1], d2[1]);
    assign if_c.nq_in = nq_model(mode[2], nd[2], d2[2]);

    function automatic int ivec(input int id);
        case (id)
            0:       return int'({if_a.i3, if_a.i2, if_a.i1, if_a.i0});
            1:       return int'({if_b.i3, if_b.i2, if_b.i1, if_b.i0});
            default: return int'({if_c.i3, if_c.i2, if_c.i1, if_c.i0});
        endcase
    endfunction

    // field: 0 busy, 1 done, 2 pass, 3 err_cnt, 4 fail_vld, 5 fail_vec
    function automatic int res(input int id, input int field);
        case (id)
            0: case (field)
                0: return int'(if_a.busy);
                1: return int'(if_a.done);
                2: return int'(if_a.pass);
                3: return int'(if_a.err_cnt);
                4: return int'(if_a.fail_vld);
                default: return int'(if_a.fail_vec);
            endcase
            1: case (field)
                0: return int'(if_b.busy);
                1: return int'(if_b.done);
                2: return int'(if_b.pass);
                3: return int'(if_b.err_cnt);
                4: return int'(if_b.fail_vld);
                default: return int'(if_b.fail_vec);
            endcase
            default: case (field)
                0: return int'(if_c.busy);
                1: return int'(if_c.done);
                2: return int'(if_c.pass);
                3: return int'(if_c.err_cnt);
                4: return int'(if_c.fail_vld);
                default: return int'(if_c.fail_vec);
            endcase
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       if_a.start = v;
            1:       if_b.start = v;
            default: if_c.start = v;
        endcase
    endtask

    task automatic set_tt(input int id, input logic [15:0] v);
        case (id)
            0:       if_a.tt = v;
            1:       if_b.tt = v;
            default: if_c.tt = v;
        endcase
    endtask

    typedef struct {
        int id;
        int edge_cyc;
        int pass;
        int err;
        int fvld;
        int fvec;
    } exp_t;

    exp_t sbq[$];

    // Monitor: every rising done is matched against the oldest expected run result.
    logic [2:0] done_prev = 3'b000;
    logic [2:0] done_now;
    exp_t       e;

    always @(negedge ck) begin
        done_now = {if_c.done, if_b.done, if_a.done};
        for (int k = 0; k < 3; k++) begin
            if (done_now[k] && !done_prev[k]) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", k, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("done_inst",     k,          e.id);
                    chk("done_edge",     cyc,        e.edge_cyc);
                    chk("done_pass",     res(k, 2),  e.pass);
                    chk("done_err_cnt",  res(k, 3),  e.err);
                    chk("done_fail_vld", res(k, 4),  e.fvld);
                    chk("done_fail_vec", res(k, 5),  e.fvec);
                end
            end
        end
        done_prev = done_now;
    end

    // Full run; optionally flips tt and pulses start at given vector indices (-1 = never).
    task automatic run(input int id, input int s, input logic [15:0] tt,
                       input int epass, input int eerr, input int efvld, input int efvec,
                       input int tt_chg_at, input int start_at);
        exp_t x;
        @(negedge ck);
        set_tt(id, tt);
        set_start(id, 1'b1);
        @(posedge ck);
        #1;
        set_start(id, 1'b0);
        x.id = id; x.edge_cyc = cyc + 16 * (s + 1);
        x.pass = epass; x.err = eerr; x.fvld = efvld; x.fvec = efvec;
        sbq.push_back(x);
        chk("busy_after_start", res(id, 0), 1);
        chk("done_after_start", res(id, 1), 0);
        for (int n = 0; n < 16; n++) begin
            chk("vec_drive", ivec(id), n);
            if (n == tt_chg_at) set_tt(id, ~tt);
            if (n == start_at) set_start(id, 1'b1);
            for (int w = 0; w <= s; w++) begin
                @(posedge ck);
                #1;
                set_start(id, 1'b0);
            end
        end
        chk("done_at_end", res(id, 1), 1);
        chk("busy_at_end", res(id, 0), 0);
        chk("vec_parked",  ivec(id),   0);
        repeat (2) @(posedge ck);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        mode[0] = 2'd0; mode[1] = 2'd0; mode[2] = 2'd0;
        if_a.start = 1'b0; if_a.abort = 1'b0; if_a.tt = 16'h7FFF;
        if_b.start = 1'b0; if_b.abort = 1'b0; if_b.tt = 16'h7FFF;
        if_c.start = 1'b0; if_c.abort = 1'b0; if_c.tt = 16'h7FFF;
        repeat (3) @(posedge ck);
        #1;
        chk("rst_vec",      ivec(0),   0);
        chk("rst_busy",     res(0, 0), 0);
        chk("rst_done",     res(0, 1), 0);
        chk("rst_pass",     res(0, 2), 0);
        chk("rst_err_cnt",  res(0, 3), 0);
        chk("rst_fail_vld", res(0, 4), 0);
        chk("rst_fail_vec", res(0, 5), 0);
        @(negedge ck);
        nrst = 1'b1;
        repeat (2) @(posedge ck);

        // ideal NAND4; tt flipped at vector 4 and start pulsed at vector 6 must not matter
        run(0, 2, 16'h7FFF, 1, 0, 0, 0, 4, 6);
        // output stuck at 1: only vector 15 disagrees
        mode[0] = 2'd1;
        run(0, 2, 16'h7FFF, 0, 1, 1, 15, -1, -1);
        // output stuck at 0, 3-bit counter: 15 mismatches saturate at 7
        mode[1] = 2'd2;
        run(1, 2, 16'h7FFF, 0, 7, 1, 0, -1, -1);
        // two-cycle lag: enough settle with SETTLE=2, only 14->15 caught with SETTLE=1
        mode[0] = 2'd3;
        run(0, 2, 16'h7FFF, 1, 0, 0, 0, -1, -1);
        mode[2] = 2'd3;
        run(2, 1, 16'h7FFF, 0, 1, 1, 15, -1, -1);

        // abort while vector 5 is driven; vectors 0..4 already failed against stuck-at-0
        mode[0] = 2'd2;
        @(negedge ck);
        if_a.tt = 16'h7FFF;
        if_a.start = 1'b1;
        @(posedge ck);
        #1;
        if_a.start = 1'b0;
        repeat (15) @(posedge ck);
        #1;
        chk("abort_pre_vec", ivec(0), 5);
        if_a.abort = 1'b1;
        @(posedge ck);
        #1;
        if_a.abort = 1'b0;
        chk("abort_vec",      ivec(0),   0);
        chk("abort_busy",     res(0, 0), 0);
        chk("abort_done",     res(0, 1), 0);
        chk("abort_err_cnt",  res(0, 3), 5);
        chk("abort_fail_vld", res(0, 4), 1);
        chk("abort_fail_vec", res(0, 5), 0);
        if_a.abort = 1'b1;
        repeat (4) @(posedge ck);
        #1;
        if_a.abort = 1'b0;
        chk("idle_busy", res(0, 0), 0);
        chk("idle_done", res(0, 1), 0);

        // reset asserted mid-run at vector 9, then a clean full run
        mode[0] = 2'd0;
        @(negedge ck);
        if_a.start = 1'b1;
        @(posedge ck);
        #1;
        if_a.start = 1'b0;
        repeat (27) @(posedge ck);
        #1;
        chk("rst_pre_vec", ivec(0), 9);
        #1;
        nrst = 1'b0;
        #1;
        chk("midrst_vec",      ivec(0),   0);
        chk("midrst_busy",     res(0, 0), 0);
        chk("midrst_done",     res(0, 1), 0);
        chk("midrst_pass",     res(0, 2), 0);
        chk("midrst_err_cnt",  res(0, 3), 0);
        chk("midrst_fail_vld", res(0, 4), 0);
        chk("midrst_fail_vec", res(0, 5), 0);
        repeat (2) @(posedge ck);
        @(negedge ck);
        nrst = 1'b1;
        repeat (2) @(posedge ck);
        run(0, 2, 16'h7FFF, 1, 0, 0, 0, -1, -1);

        repeat (4) @(posedge ck);
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
